// File: rtl/mem_lsu.sv
// Handshaked load/store stage between EX and WB: one bus request per instruction,
// load extraction/extension, WB hold under backpressure. Optional ALE check via LSU_ALE_CHECK_EN.
module mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [4:0]              wd_i,
  input  logic                    wreg_i,
  input  logic [31:0]             wdata_i,
  input  logic [7:0]              aluop_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [31:0]             reg2_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic                    req_we_o,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [DATA_WIDTH/8-1:0] req_sel_o,
  output logic [DATA_WIDTH-1:0]   req_wdata_o,
  input  logic                    resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   resp_rdata_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [31:0]             wdata_o,
  output logic                    ale_o,
  output logic [ADDR_WIDTH-1:0]   badv_o
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);

  localparam logic [7:0] EXE_LD_B_OP  = 8'h20;
  localparam logic [7:0] EXE_LD_H_OP  = 8'h21;
  localparam logic [7:0] EXE_LD_W_OP  = 8'h22;
  localparam logic [7:0] EXE_LD_BU_OP = 8'h24;
  localparam logic [7:0] EXE_LD_HU_OP = 8'h25;
  localparam logic [7:0] EXE_ST_B_OP  = 8'h28;
  localparam logic [7:0] EXE_ST_H_OP  = 8'h29;
  localparam logic [7:0] EXE_ST_W_OP  = 8'h2A;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e                state_q;
  logic [OFS-1:0]        ofs_q;
  logic [1:0]            sz_q;
  logic                  sgn_q;
  logic                  req_we_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [NB-1:0]         req_sel_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [4:0]            wd_q;
  logic                  wreg_q;
  logic [31:0]           wdata_q;
  logic                  ale_q;
  logic [ADDR_WIDTH-1:0] badv_q;

  logic                  is_ld_d, is_st_d, sgn_d, ale_d, acc;
  logic [1:0]            sz_d;
  logic [OFS-1:0]        lowmask_d, ofs_d;
  logic [NB-1:0]         sel_base_d, sel_d;
  logic [DATA_WIDTH-1:0] wdata_rep_d;
  logic [31:0]           lane_w, ext_d;

  always_comb begin
    is_ld_d = 1'b0;
    is_st_d = 1'b0;
    sz_d    = 2'd0;
    sgn_d   = 1'b0;
    case (aluop_i)
      EXE_LD_B_OP:  begin is_ld_d = 1'b1; sgn_d = 1'b1; end
      EXE_LD_H_OP:  begin is_ld_d = 1'b1; sgn_d = 1'b1; sz_d = 2'd1; end
      EXE_LD_W_OP:  begin is_ld_d = 1'b1; sz_d = 2'd2; end
      EXE_LD_BU_OP: is_ld_d = 1'b1;
      EXE_LD_HU_OP: begin is_ld_d = 1'b1; sz_d = 2'd1; end
      EXE_ST_B_OP:  is_st_d = 1'b1;
      EXE_ST_H_OP:  begin is_st_d = 1'b1; sz_d = 2'd1; end
      EXE_ST_W_OP:  begin is_st_d = 1'b1; sz_d = 2'd2; end
      default: ;
    endcase

    lowmask_d = (sz_d == 2'd0) ? '0 : (sz_d == 2'd1) ? OFS'(1) : OFS'(3);
`ifdef LSU_ALE_CHECK_EN
    ale_d = (is_ld_d | is_st_d) & (|(mem_addr_i[OFS-1:0] & lowmask_d));
    ofs_d = mem_addr_i[OFS-1:0];
`else
    // Misaligned accesses round down to the access size.
    ale_d = 1'b0;
    ofs_d = mem_addr_i[OFS-1:0] & ~lowmask_d;
`endif

    sel_base_d = (sz_d == 2'd0) ? NB'(1) : (sz_d == 2'd1) ? NB'(3) : NB'(15);
    sel_d      = sel_base_d << ofs_d;
    case (sz_d)
      2'd0:    wdata_rep_d = {NB{reg2_i[7:0]}};
      2'd1:    wdata_rep_d = {(NB/2){reg2_i[15:0]}};
      default: wdata_rep_d = {(NB/4){reg2_i}};
    endcase

    lane_w = 32'(resp_rdata_i >> {ofs_q, 3'b000});
    case (sz_q)
      2'd0:    ext_d = sgn_q ? {{24{lane_w[7]}}, lane_w[7:0]} : {24'h0, lane_w[7:0]};
      2'd1:    ext_d = sgn_q ? {{16{lane_w[15]}}, lane_w[15:0]} : {16'h0, lane_w[15:0]};
      default: ext_d = lane_w;
    endcase
  end

  assign in_ready_o  = ~rst & ~flush_i &
                       ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i));
  assign acc         = in_valid_i & in_ready_o;
  assign req_valid_o = (state_q == S_REQ);
  assign out_valid_o = (state_q == S_DONE);
  assign req_we_o    = req_we_q;
  assign req_addr_o  = req_addr_q;
  assign req_sel_o   = req_sel_q;
  assign req_wdata_o = req_wdata_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign ale_o       = ale_q;
  assign badv_o      = badv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ofs_q       <= '0;
      sz_q        <= '0;
      sgn_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_sel_q   <= '0;
      req_wdata_q <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      ale_q       <= 1'b0;
      badv_q      <= '0;
    end else if (flush_i) begin
      // A load the bus has taken still owes a response; drain it to keep ordering.
      case (state_q)
        S_REQ:   state_q <= (req_ready_i & ~req_we_q) ? S_DRAIN : S_IDLE;
        S_WAIT:  state_q <= resp_valid_i ? S_IDLE : S_DRAIN;
        S_DRAIN: state_q <= resp_valid_i ? S_IDLE : S_DRAIN;
        default: state_q <= S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (acc) begin
            wd_q        <= wd_i;
            wreg_q      <= wreg_i & ~ale_d;
            wdata_q     <= wdata_i;
            ale_q       <= ale_d;
            badv_q      <= ale_d ? mem_addr_i : '0;
            req_we_q    <= is_st_d;
            req_addr_q  <= {mem_addr_i[ADDR_WIDTH-1:OFS], OFS'(0)};
            req_sel_q   <= sel_d;
            req_wdata_q <= wdata_rep_d;
            ofs_q       <= ofs_d;
            sz_q        <= sz_d;
            sgn_q       <= sgn_d;
            state_q     <= ((is_ld_d | is_st_d) & ~ale_d) ? S_REQ : S_DONE;
          end else if (state_q == S_DONE && out_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: if (req_ready_i) state_q <= req_we_q ? S_DONE : S_WAIT;
        S_WAIT: if (resp_valid_i) begin
          wdata_q <= ext_d;
          state_q <= S_DONE;
        end
        S_DRAIN: if (resp_valid_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: 32-bit and 64-bit instances driven by the same stimulus.
module tb_mem_lsu;
  localparam logic [7:0] LD_B  = 8'h20;
  localparam logic [7:0] LD_H  = 8'h21;
  localparam logic [7:0] LD_W  = 8'h22;
  localparam logic [7:0] LD_BU = 8'h24;
  localparam logic [7:0] ST_H  = 8'h29;
  localparam logic [7:0] OP_ADD = 8'h01;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, req_ready, resp_valid, wreg;
  logic [4:0]  wd;
  logic [31:0] wdata, addr, reg2, rdata32;
  logic [7:0]  aluop;
  logic [63:0] rdata64;

  logic        in_ready32, req_valid32, req_we32, out_valid32, wreg32, ale32;
  logic [31:0] req_addr32, req_wdata32, wdata_o32, badv32;
  logic [3:0]  req_sel32;
  logic [4:0]  wd32;
  logic        in_ready64, req_valid64, req_we64, out_valid64, wreg64, ale64;
  logic [31:0] req_addr64, wdata_o64, badv64;
  logic [63:0] req_wdata64;
  logic [7:0]  req_sel64;
  logic [4:0]  wd64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .aluop_i(aluop), .mem_addr_i(addr), .reg2_i(reg2),
    .req_valid_o(req_valid32), .req_ready_i(req_ready), .req_we_o(req_we32),
    .req_addr_o(req_addr32), .req_sel_o(req_sel32), .req_wdata_o(req_wdata32),
    .resp_valid_i(resp_valid), .resp_rdata_i(rdata32),
    .out_valid_o(out_valid32), .out_ready_i(out_ready), .wd_o(wd32), .wreg_o(wreg32),
    .wdata_o(wdata_o32), .ale_o(ale32), .badv_o(badv32));

  mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u64 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .aluop_i(aluop), .mem_addr_i(addr), .reg2_i(reg2),
    .req_valid_o(req_valid64), .req_ready_i(req_ready), .req_we_o(req_we64),
    .req_addr_o(req_addr64), .req_sel_o(req_sel64), .req_wdata_o(req_wdata64),
    .resp_valid_i(resp_valid), .resp_rdata_i(rdata64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready), .wd_o(wd64), .wreg_o(wreg64),
    .wdata_o(wdata_o64), .ale_o(ale64), .badv_o(badv64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2);
    aluop = op; addr = a; reg2 = r2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; req_ready = 1'b1;
    resp_valid = 1'b0; wreg = 1'b0; wd = '0; wdata = '0; addr = '0; reg2 = '0;
    aluop = '0; rdata32 = '0; rdata64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready32, 0);
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_req_valid", req_valid32, 0);
    chk("rst_wdata", wdata_o32, 0);
    rst = 1'b0; #1;
    chk("rst_rel_in_ready", in_ready32, 1);

    // ld.b at 0x1003, response MSB-set in lane 3
    wd = 5'd5; wreg = 1'b1;
    issue(LD_B, 32'h1003, 32'h0);
    chk("ldb_req_valid", req_valid32, 1);
    chk("ldb_sel", req_sel32, 4'b1000);
    chk("ldb_addr", req_addr32, 32'h1000);
    chk("ldb_we", req_we32, 0);
    chk("ldb_sel64", req_sel64, 8'b0000_1000);
    chk("ldb_in_ready_req", in_ready32, 0);
    chk("ldb_out_valid_c1", out_valid32, 0);
    tick();
    chk("ldb_out_valid_c2", out_valid32, 0);
    resp_valid = 1'b1; rdata32 = 32'h8000_0000; rdata64 = 64'h0000_0000_8000_0000;
    tick();
    resp_valid = 1'b0;
    chk("ldb_out_valid_c3", out_valid32, 1);
    chk("ldb_wdata", wdata_o32, 32'hFFFF_FF80);
    chk("ldb_wd", wd32, 5'd5);
    chk("ldb_wdata64", wdata_o64, 32'hFFFF_FF80);
    tick();

    // ld.bu, same access
    issue(LD_BU, 32'h1003, 32'h0);
    tick();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("ldbu_wdata", wdata_o32, 32'h0000_0080);
    chk("ldbu_wdata64", wdata_o64, 32'h0000_0080);
    tick();

    // st.h at 0x2006
    wreg = 1'b0;
    issue(ST_H, 32'h2006, 32'h1234_ABCD);
    chk("sth_req_valid64", req_valid64, 1);
    chk("sth_we64", req_we64, 1);
    chk("sth_addr64", req_addr64, 32'h2000);
    chk("sth_sel64", req_sel64, 8'b1100_0000);
    chk("sth_wdata64", req_wdata64, 64'hABCD_ABCD_ABCD_ABCD);
    chk("sth_addr32", req_addr32, 32'h2004);
    chk("sth_sel32", req_sel32, 4'b1100);
    chk("sth_wdata32", req_wdata32, 32'hABCD_ABCD);
    chk("sth_out_valid_c1", out_valid64, 0);
    tick();
    chk("sth_out_valid_c2", out_valid64, 1);
    chk("sth_req_valid_done", req_valid64, 0);
    tick();

    // ld.w with bus stalled three cycles; inputs change underneath
    wreg = 1'b1; req_ready = 1'b0;
    issue(LD_W, 32'h40, 32'h0);
    addr = 32'hFFFF_FFFC; aluop = ST_H;
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_valid", req_valid32, 1);
      chk("stall_addr", req_addr32, 32'h40);
      chk("stall_sel", req_sel32, 4'b1111);
      chk("stall_we", req_we32, 0);
      chk("stall_in_ready", in_ready32, 0);
      if (i == 3) req_ready = 1'b1;
      tick();
    end
    chk("stall_wait_req_valid", req_valid32, 0);
    resp_valid = 1'b1; rdata32 = 32'hDEAD_BEEF; rdata64 = 64'h0000_0000_DEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    chk("stall_wdata", wdata_o32, 32'hDEAD_BEEF);
    tick();

    // flush in REQ before acceptance: no request leaks
    req_ready = 1'b0;
    issue(LD_W, 32'h50, 32'h0);
    flush = 1'b1; #1;
    chk("flreq_in_ready", in_ready32, 0);
    tick();
    flush = 1'b0; req_ready = 1'b1; #1;
    chk("flreq_req_valid", req_valid32, 0);
    chk("flreq_out_valid", out_valid32, 0);
    chk("flreq_in_ready_idle", in_ready32, 1);

    // flush in WAIT, response two cycles later
    issue(LD_H, 32'h12, 32'h0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("drain_in_ready_a", in_ready32, 0);
    chk("drain_out_valid_a", out_valid32, 0);
    tick();
    chk("drain_in_ready_b", in_ready32, 0);
    resp_valid = 1'b1; rdata32 = 32'h5566_7788;
    tick();
    resp_valid = 1'b0;
    chk("drain_in_ready_after", in_ready32, 1);
    chk("drain_out_valid_after", out_valid32, 0);
    tick();
    chk("drain_out_valid_later", out_valid32, 0);

    // reset during a transaction
    issue(LD_W, 32'h60, 32'h0);
    chk("mrst_req_valid_pre", req_valid32, 1);
    rst = 1'b1; #1;
    chk("mrst_req_valid", req_valid32, 0);
    chk("mrst_in_ready", in_ready32, 0);
    tick();
    rst = 1'b0; #1;
    chk("mrst_in_ready_rel", in_ready32, 1);

    // misaligned ld.w at 0x3002
    wreg = 1'b1;
    issue(LD_W, 32'h3002, 32'h0);
`ifdef LSU_ALE_CHECK_EN
    chk("ale_req_valid", req_valid32, 0);
    chk("ale_out_valid", out_valid32, 1);
    chk("ale_flag", ale32, 1);
    chk("ale_badv", badv32, 32'h3002);
    chk("ale_wreg", wreg32, 0);
    tick();
`else
    chk("mis_req_valid", req_valid32, 1);
    chk("mis_addr", req_addr32, 32'h3000);
    chk("mis_sel", req_sel32, 4'b1111);
    chk("mis_ale", ale32, 0);
    tick();
    resp_valid = 1'b1; rdata32 = 32'h1122_3344;
    tick();
    resp_valid = 1'b0;
    chk("mis_wdata", wdata_o32, 32'h1122_3344);
    chk("mis_badv", badv32, 0);
    tick();
`endif

    // back-to-back non-memory ops, then WB backpressure
    aluop = OP_ADD; wd = 5'd7; in_valid = 1'b1; wdata = 32'hA1;
    tick();
    chk("alu_out_valid_1", out_valid32, 1);
    chk("alu_wdata_1", wdata_o32, 32'hA1);
    chk("alu_req_valid", req_valid32, 0);
    wdata = 32'hB2;
    tick();
    chk("alu_wdata_2", wdata_o32, 32'hB2);
    wdata = 32'hC3;
    tick();
    chk("alu_wdata_3", wdata_o32, 32'hC3);
    out_ready = 1'b0; wdata = 32'hD4; #1;
    chk("bp_in_ready_0", in_ready32, 0);
    tick();
    chk("bp_out_valid_1", out_valid32, 1);
    chk("bp_wdata_1", wdata_o32, 32'hC3);
    tick();
    chk("bp_wdata_2", wdata_o32, 32'hC3);
    out_ready = 1'b1; #1;
    chk("bp_in_ready_1", in_ready32, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_wdata_next", wdata_o32, 32'hD4);
    chk("bp_wd", wd32, 5'd7);
    tick();
    chk("bp_out_valid_idle", out_valid32, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised, handshaked load/store stage replacing the purely combinational MEM stage between EX and WB. It accepts one instruction at a time from EX and issues at most one request to a data bus of configurable width. It waits for load data through a valid/ready request channel and a response channel, then extracts, extends and aligns the load data. The result is held for WB under backpressure, and a flush is honoured without losing bus ordering.

## Interface
- `DATA_WIDTH`, 32: data bus width, 32 or 64; `NB = DATA_WIDTH/8`, `OFS = log2(NB)`.
- `ADDR_WIDTH`, 32: address width.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: discard the in-flight instruction.
- `in_valid_i` in 1 / `in_ready_o` out 1: EX handshake.
- `wd_i` in `RegAddrBus`, `wreg_i` in 1, `wdata_i` in `RegBus`: writeback fields from EX.
- `aluop_i` in `AluOpBus`: op code, decoded against `EXE_LD_{B,H,W,BU,HU}_OP` / `EXE_ST_{B,H,W}_OP`.
- `mem_addr_i` in ADDR_WIDTH: effective byte address.
- `reg2_i` in `RegBus`: store data.
- `req_valid_o` out 1 / `req_ready_i` in 1: bus request handshake.
- `req_we_o` out 1: 1 for store.
- `req_addr_o` out ADDR_WIDTH: `mem_addr` with the low OFS bits cleared.
- `req_sel_o` out NB: byte-lane enables.
- `req_wdata_o` out DATA_WIDTH: lane-replicated store data.
- `resp_valid_i` in 1, `resp_rdata_i` in DATA_WIDTH: load response.
- `out_valid_o` out 1 / `out_ready_i` in 1: WB handshake.
- `wd_o` out `RegAddrBus`, `wreg_o` out 1, `wdata_o` out `RegBus`: writeback result.
- `ale_o` out 1, `badv_o` out ADDR_WIDTH: address-alignment exception and faulting address.

## Operation
- Byte order is little-endian. Byte at offset `k = addr[OFS-1:0]` occupies lanes `8k+7:8k`.
- Access size: B = 1 byte, H = 2 bytes, W = 4 bytes.
- `req_sel_o` has `size` consecutive ones starting at bit k.
- Store data `reg2_i[8*size-1:0]` is replicated across all lanes of `req_wdata_o`.
- Loads select `size` bytes from lane k. B/H are sign-extended to 32 bits; BU/HU are zero-extended; W is passed unchanged.
- Non-memory ops pass `wd/wreg/wdata` through without a bus request.
- States:
  - IDLE: `in_ready_o=1`. On accept, a memory op goes to REQ, or to DONE if it raises an ALE. A non-memory op goes to DONE.
  - REQ: `req_valid_o=1` with all request fields stable until `req_ready_i`. On acceptance, a load goes to WAIT and a store goes to DONE.
  - WAIT: the first `resp_valid_i` captures the extended data into `wdata_o`; next state DONE.
  - DONE: `out_valid_o=1` with outputs stable. On `out_ready_i`: IDLE, or REQ/DONE directly if `in_valid_i` is accepted the same cycle.
  - DRAIN: waits for `resp_valid_i`, discards the data, then goes to IDLE.
- `in_ready_o = (state==IDLE) | (state==DONE & out_ready_i)`; forced to 0 while `flush_i` is high.
- `flush_i` behaviour by state:
  - IDLE, DONE, or REQ without same-cycle acceptance: go to IDLE, no request leaks.
  - REQ with same-cycle acceptance of a load, or WAIT without a response: go to DRAIN.
  - WAIT with a response in the same cycle: go to IDLE.
  - A store already accepted by the bus is not recalled.
- `resp_valid_i` outside WAIT/DRAIN is ignored.

## Timing
- Reset: state IDLE; every output 0 except `in_ready_o`, which is 1 once `rst` is deasserted.
- Non-memory op: `out_valid_o` in the cycle after acceptance (latency 1).
- Store with `req_ready_i=1`: request in cycle +1, `out_valid_o` in cycle +2.
- Load with `req_ready_i=1` and response one cycle after request: request in cycle +1, response in +2, `out_valid_o` in +3.
- The earliest valid response is the cycle after request acceptance.
- Throughput: one instruction per cycle for non-memory ops under continuous `out_ready_i`.
- `rst` mid-transaction: immediate IDLE. The bus side must also be reset, and no response is expected afterwards.

## Configuration
- `LSU_ALE_CHECK_EN` defined:
  - Triggers on H/HU/ST_H with `addr[0]=1`, or W/ST_W with `addr[1:0]!=0`.
  - No request is issued; DONE is entered with `ale_o=1`, `badv_o=mem_addr_i`, `wreg_o=0`.
- `LSU_ALE_CHECK_EN` undefined: `ale_o` and `badv_o` are tied to 0. Address bits below the access size are cleared before lane selection, so misaligned accesses silently round down.

## Test plan
- DATA_WIDTH=32, ld.b at 0x1003 with rdata 0x80_00_00_00 -> `req_sel_o=4'b1000`, `wdata_o=0xFFFFFF80`. The same access with ld.bu -> `wdata_o=0x00000080`.
- DATA_WIDTH=64, st.h at 0x2006 with reg2 0x1234ABCD -> `req_addr_o=0x2000`, `req_sel_o=8'b11000000`, `req_wdata_o=0xABCDABCDABCDABCD`, `out_valid_o` two cycles after acceptance.
- Load with `req_ready_i` held low for 3 cycles -> `req_valid_o` and all request fields stable for 4 cycles; `in_ready_o=0` throughout.
- `flush_i` asserted in WAIT, response arriving 2 cycles later -> state DRAIN, response discarded, `out_valid_o` never asserted, `in_ready_o=1` the cycle after the response.
- With `LSU_ALE_CHECK_EN` defined, ld.w at 0x3002 -> no `req_valid_o`, `ale_o=1`, `badv_o=0x3002`, `wreg_o=0`. With the macro undefined -> request at 0x3000 with `sel=4'b1111`.
- Back-to-back add/sub ops with `out_ready_i=1` -> one result per cycle. `out_ready_i` low for 2 cycles -> outputs held and no input accepted.
